// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM state encoding and counter width for the
// multiply/divide unit.
// Optional build macro: MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU real
// multi-cycle ops. Without it those codes behave like NONE.
package mdu_pkg;

    localparam int MDU_CNT_W = 4;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // True for ops that use the divide latency rather than the multiply one.
    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
// Produces the 64-bit {HI,LO} result that the controller parks in its
// pending registers. Divide-by-zero and the INT_MIN/-1 overflow are
// resolved here so the controller never sees an undefined value.
// Optional build macro: MDU_MADD_EN adds the accumulate/subtract ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);

    logic [63:0] s_prod_s;
    logic [63:0] u_prod_s;
    logic [31:0] rs_mag_s;
    logic [31:0] rt_mag_s;
    logic [31:0] rt_mag_safe_s;
    logic [31:0] rt_safe_s;
    logic [31:0] s_quo_mag_s;
    logic [31:0] s_rem_mag_s;
    logic [31:0] s_quo_s;
    logic [31:0] s_rem_s;
    logic [31:0] u_quo_s;
    logic [31:0] u_rem_s;
    logic        rt_zero_s;
    logic        div_ovf_s;

    // Full-width products; sign extension makes the 64-bit multiply exact.
    assign s_prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign u_prod_s = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed divide is done on magnitudes so truncation toward zero and the
    // remainder-follows-dividend rule are explicit rather than tool-defined.
    assign rs_mag_s      = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    assign rt_mag_s      = rt_i[31] ? (32'd0 - rt_i) : rt_i;
    assign rt_zero_s     = (rt_i == 32'd0);
    assign div_ovf_s     = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
    assign rt_mag_safe_s = rt_zero_s ? 32'd1 : rt_mag_s;
    assign rt_safe_s     = rt_zero_s ? 32'd1 : rt_i;
    assign s_quo_mag_s   = rs_mag_s / rt_mag_safe_s;
    assign s_rem_mag_s   = rs_mag_s % rt_mag_safe_s;
    assign s_quo_s       = (rs_i[31] ^ rt_i[31]) ? (32'd0 - s_quo_mag_s) : s_quo_mag_s;
    assign s_rem_s       = rs_i[31] ? (32'd0 - s_rem_mag_s) : s_rem_mag_s;
    assign u_quo_s       = rs_i / rt_safe_s;
    assign u_rem_s       = rs_i % rt_safe_s;

    // Result select per op; anything that is not arithmetic keeps HI/LO.
    always_comb begin
        res_o = {hi_i, lo_i};
        case (op_i)
            OP_MULT:  res_o = s_prod_s;
            OP_MULTU: res_o = u_prod_s;
            OP_DIV: begin
                if (rt_zero_s) begin
                    res_o = {rs_i, 32'hFFFF_FFFF};
                end else if (div_ovf_s) begin
                    res_o = {32'd0, 32'h8000_0000};
                end else begin
                    res_o = {s_rem_s, s_quo_s};
                end
            end
            OP_DIVU: begin
                if (rt_zero_s) begin
                    res_o = {rs_i, 32'hFFFF_FFFF};
                end else begin
                    res_o = {u_rem_s, u_quo_s};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res_o = {hi_i, lo_i} + s_prod_s;
            OP_MADDU: res_o = {hi_i, lo_i} + u_prod_s;
            OP_MSUB:  res_o = {hi_i, lo_i} - s_prod_s;
            OP_MSUBU: res_o = {hi_i, lo_i} - u_prod_s;
`endif
            default:  res_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer. Owns HI/LO, models the fixed
// multiply/divide latency with a down-counter and raises the D-stage stall.
// The result is computed at the start edge and parked in pend_hi/pend_lo;
// it becomes architecturally visible only when the counter expires.
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDU_req,
    input  logic [3:0]  E_MDU_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic        D_is_MDU,
    output logic [31:0] E_MDU_out,
    output logic        MDU_busy,
    output logic        HCU_MDU_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);
    localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);
    localparam logic [MDU_CNT_W-1:0] CNT_ZERO = MDU_CNT_W'(0);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          pend_hi_q, pend_hi_d;
    logic [31:0]          pend_lo_q, pend_lo_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 start_s;
    logic [MDU_CNT_W-1:0] start_cnt_s;
    logic [63:0]          arith_res_s;

    mdu_arith u_arith (
        .op_i  (E_MDU_op),
        .rs_i  (E_rs_data),
        .rt_i  (E_rt_data),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (arith_res_s)
    );

    // Accept a long op only from IDLE; pick its latency from the op class.
    always_comb begin
        start_s     = E_MDU_req && (state_q == ST_IDLE) && is_long_op(E_MDU_op);
        start_cnt_s = MULT_CNT;
        if (is_div_op(E_MDU_op)) begin
            start_cnt_s = DIV_CNT;
        end else begin
            start_cnt_s = MULT_CNT;
        end
    end

    // Next-state logic: start, count down, commit pending result, MTHI/MTLO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_BUSY;
                    cnt_d     = start_cnt_s;
                    pend_hi_d = arith_res_s[63:32];
                    pend_lo_d = arith_res_s[31:0];
                end else if (E_MDU_req && (E_MDU_op == OP_MTHI)) begin
                    hi_d = E_rs_data;
                end else if (E_MDU_req && (E_MDU_op == OP_MTLO)) begin
                    lo_d = E_rs_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Requests arriving here are ignored; the stall keeps them out.
                if (cnt_q == CNT_ONE) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // State, counter, pending and committed registers with async clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // Move-from read port; reads committed values, so old HI/LO while busy.
    always_comb begin
        E_MDU_out = 32'd0;
        case (E_MDU_op)
            OP_MFHI: E_MDU_out = hi_q;
            OP_MFLO: E_MDU_out = lo_q;
            default: E_MDU_out = 32'd0;
        endcase
    end

    // Stall covers the start cycle too, so D never issues into a starting op.
    always_comb begin
        HCU_MDU_stall = D_is_MDU && (busy_q || start_s);
    end

    assign MDU_busy = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Stimulus computes expected
// HI/LO from plain integer arithmetic and queues it; a negedge monitor pops
// and compares whenever busy drops or a move-from op is presented.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        E_MDU_req;
    logic [3:0]  E_MDU_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        D_is_MDU;
    logic [31:0] E_MDU_out;
    logic        MDU_busy;
    logic        HCU_MDU_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mf_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk           (clk),
        .reset         (reset),
        .E_MDU_req     (E_MDU_req),
        .E_MDU_op      (E_MDU_op),
        .E_rs_data     (E_rs_data),
        .E_rt_data     (E_rt_data),
        .D_is_MDU      (D_is_MDU),
        .E_MDU_out     (E_MDU_out),
        .MDU_busy      (MDU_busy),
        .HCU_MDU_stall (HCU_MDU_stall),
        .HI            (HI),
        .LO            (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic tb_is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
    endfunction

    // Reference: architectural {HI,LO} after op, from integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        int              a, b, q, r;
        int unsigned     ua, ub;
        sp = longint'($signed(rs)) * longint'($signed(rt));
        up = {32'd0, rs} * {32'd0, rt};
        a  = rs;
        b  = rt;
        ua = rs;
        ub = rt;
        case (op)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_DIV: begin
                if (b == 0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = a / b;
                r = a % b;
                return {r, q};
            end
            OP_DIVU: begin
                if (ub == 0) return {rs, 32'hFFFF_FFFF};
                return {ua % ub, ua / ub};
            end
            OP_MTHI:  return {rs, lo};
            OP_MTLO:  return {hi, rs};
`ifdef MDU_MADD_EN
            OP_MADD:  return {hi, lo} + sp;
            OP_MADDU: return {hi, lo} + up;
            OP_MSUB:  return {hi, lo} - sp;
            OP_MSUBU: return {hi, lo} - up;
`endif
            default:  return {hi, lo};
        endcase
    endfunction

    // Monitor: latency/result on busy fall, read data on move-from ops.
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            exp_t e;
            logic [31:0] mv;
            chk("req_while_busy", {63'd0, E_MDU_req & MDU_busy}, 64'd0);
            if (MDU_busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                chk("done_pending", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("latency", busy_cnt, e.lat);
                    chk("hi_lo", {HI, LO}, {e.hi, e.lo});
                end
                busy_cnt = 0;
            end
            prev_busy = MDU_busy;
            if (E_MDU_req && (E_MDU_op == OP_MFHI || E_MDU_op == OP_MFLO)) begin
                chk("mf_pending", {63'd0, mf_q.size() != 0}, 64'd1);
                if (mf_q.size() != 0) begin
                    mv = mf_q.pop_front();
                    chk("mf_out", {32'd0, E_MDU_out}, {32'd0, mv});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for the unit to go idle, exercising the stall while it is busy.
    task automatic wait_idle;
        int n;
        n = 0;
        while (MDU_busy && n < 40) begin
            D_is_MDU = 1'($urandom_range(0, 1));
            #1;
            chk("stall_busy", {63'd0, HCU_MDU_stall}, {63'd0, D_is_MDU});
            tick();
            n++;
        end
        D_is_MDU = 1'b0;
        chk("idle_timeout", {63'd0, MDU_busy}, 64'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] nv;
        logic        lng;
        exp_t        e;
        wait_idle();
        lng = tb_is_long(op);
        nv  = model(op, rs, rt, m_hi, m_lo);
        E_MDU_req = 1'b1;
        E_MDU_op  = op;
        E_rs_data = rs;
        E_rt_data = rt;
        D_is_MDU  = 1'b1;
        #1;
        chk("stall_start", {63'd0, HCU_MDU_stall}, {63'd0, lng});
        if (lng) begin
            e.hi  = nv[63:32];
            e.lo  = nv[31:0];
            e.lat = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
            exp_q.push_back(e);
        end
        if (op == OP_MFHI) mf_q.push_back(m_hi);
        if (op == OP_MFLO) mf_q.push_back(m_lo);
        m_hi = nv[63:32];
        m_lo = nv[31:0];
        tick();
        E_MDU_req = 1'b0;
        E_MDU_op  = OP_NONE;
        D_is_MDU  = 1'b0;
        if (!lng) begin
            chk("no_busy", {63'd0, MDU_busy}, 64'd0);
            chk("regs_short_op", {HI, LO}, {m_hi, m_lo});
        end
    endtask

    task automatic dchk(input string name, input logic [31:0] eh, input logic [31:0] el);
        wait_idle();
        chk(name, {HI, LO}, {eh, el});
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [13];
        ops = '{OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO,
                OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        reset     = 1'b0;
        E_MDU_req = 1'b0;
        E_MDU_op  = OP_NONE;
        E_rs_data = 32'd0;
        E_rt_data = 32'd0;
        D_is_MDU  = 1'b0;
        tick();
        tick();
        chk("reset_state", {HI, LO}, 64'd0);
        chk("reset_busy", {63'd0, MDU_busy}, 64'd0);
        reset = 1'b1;
        tick();

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        dchk("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(OP_MFHI, 32'd0, 32'd0);
        issue(OP_DIVU, 32'd100, 32'd7);
        dchk("divu", 32'd2, 32'd14);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        dchk("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'd5, 32'd0);
        dchk("div_zero", 32'd5, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        dchk("div_ovf", 32'd0, 32'h8000_0000);
        issue(OP_MTLO, 32'h1234, 32'd0);
        issue(OP_MFLO, 32'd0, 32'd0);
        issue(OP_MTHI, 32'hA5A5, 32'd0);

        // Request low with a MULT code on the bus: nothing starts.
        E_MDU_op  = OP_MULT;
        D_is_MDU  = 1'b1;
        #1;
        chk("noreq_stall", {63'd0, HCU_MDU_stall}, 64'd0);
        tick();
        chk("noreq_busy", {63'd0, MDU_busy}, 64'd0);
        E_MDU_op = OP_NONE;
        D_is_MDU = 1'b0;

        // Async reset in the middle of a divide.
        issue(OP_DIV, 32'd1000, 32'd3);
        tick();
        tick();
        tick();
        chk("div_inflight", {63'd0, MDU_busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, MDU_busy}, 64'd0);
        chk("async_rst_regs", {HI, LO}, 64'd0);
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();

`ifdef MDU_MADD_EN
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd10, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
        dchk("madd", 32'd0, 32'd22);
`else
        issue(OP_MTLO, 32'd10, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
        dchk("madd_off", 32'd0, 32'd10);
`endif

        for (int i = 0; i < 60; i++) begin
            issue(ops[$urandom_range(0, 12)], rnd_operand(), rnd_operand());
        end

        wait_idle();
        tick();
        chk("exp_drained", exp_q.size(), 64'd0);
        chk("mf_drained", mf_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
